// File: rtl/hash_job_ctrl.sv
// rtl/hash_job_ctrl.sv - header loader, hasher sequencer and minimum-result scanner
module hash_job_ctrl #(
  parameter int unsigned  NUM_NONCES = 16,
  parameter logic [15:0]  MSG_BASE   = 16'h0000,
  parameter logic [15:0]  OUT_BASE   = 16'h0040,
  parameter int unsigned  HDR_WORDS  = 19
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [31:0] hdr_data,
  input  logic [31:0] target,
  output logic        hash_start,
  input  logic        hash_done,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        result_valid,
  output logic        found,
  output logic [7:0]  best_nonce,
  output logic [31:0] best_hash
);

  localparam int CW = $clog2(NUM_NONCES + 3);
  localparam int HW = $clog2(HDR_WORDS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_READ   = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;

  logic [2:0]    state;
  logic [HW-1:0] hdr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [1:0]    wait_cnt;
  logic [31:0]   target_q;
  logic [31:0]   run_min;
  logic [7:0]    run_nonce;
  logic          run_found;
  logic          hs;
  logic          capture;
  logic [31:0]   nxt_min;
  logic [7:0]    nxt_nonce;
  logic          nxt_found;

  assign hdr_ready      = (state == S_IDLE) || (state == S_LOAD);
  assign hs             = hdr_valid && hdr_ready;
  assign mem_we         = hs;
  assign mem_write_data = hs ? hdr_data : 32'h0;
  assign hash_start     = (state == S_START);
  assign busy           = (state != S_IDLE);
  assign result_valid   = (state == S_REPORT);

  always_comb begin
    mem_addr = 16'h0;
    if (hs) begin
      mem_addr = (state == S_IDLE) ? MSG_BASE : MSG_BASE + 16'(hdr_cnt);
    end else if ((state == S_READ) && (rd_cnt < CW'(NUM_NONCES))) begin
      mem_addr = OUT_BASE + 16'(rd_cnt);
    end
  end

  // Read data lags its address by two cycles, so READ cycle n carries nonce n-2.
  assign capture = (state == S_READ) && (rd_cnt >= CW'(2));

  always_comb begin
    nxt_min   = run_min;
    nxt_nonce = run_nonce;
    nxt_found = run_found;
    if (capture) begin
      if (mem_read_data < run_min) begin
        nxt_min   = mem_read_data;
        nxt_nonce = 8'(rd_cnt - CW'(2));
      end
      if (mem_read_data < target_q) begin
        nxt_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      hdr_cnt    <= '0;
      rd_cnt     <= '0;
      wait_cnt   <= 2'd0;
      target_q   <= 32'h0;
      run_min    <= 32'hFFFF_FFFF;
      run_nonce  <= 8'd0;
      run_found  <= 1'b0;
      found      <= 1'b0;
      best_nonce <= 8'd0;
      best_hash  <= 32'hFFFF_FFFF;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            target_q  <= target;
            run_min   <= 32'hFFFF_FFFF;
            run_nonce <= 8'd0;
            run_found <= 1'b0;
            if (HDR_WORDS == 1) begin
              state <= S_START;
            end else begin
              hdr_cnt <= HW'(1);
              state   <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (hs) begin
            if (hdr_cnt == HW'(HDR_WORDS - 1)) begin
              hdr_cnt <= '0;
              state   <= S_START;
            end else begin
              hdr_cnt <= hdr_cnt + HW'(1);
            end
          end
        end
        S_START: begin
          wait_cnt <= 2'd0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // The first two WAIT cycles may still see done from the previous job.
          if (wait_cnt != 2'd2) begin
            wait_cnt <= wait_cnt + 2'd1;
          end else if (hash_done) begin
            rd_cnt <= '0;
            state  <= S_READ;
          end
        end
        S_READ: begin
          run_min   <= nxt_min;
          run_nonce <= nxt_nonce;
          run_found <= nxt_found;
          if (rd_cnt == CW'(NUM_NONCES + 1)) begin
            found      <= nxt_found;
            best_nonce <= nxt_nonce;
            best_hash  <= nxt_min;
            state      <= S_REPORT;
          end else begin
            rd_cnt <= rd_cnt + CW'(1);
          end
        end
        S_REPORT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_job_ctrl.sv
// tb/tb_hash_job_ctrl.sv - table-driven jobs with result scoreboard for hash_job_ctrl
module tb_hash_job_ctrl;

  localparam int NN = 16;
  localparam int HWORDS = 19;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [31:0] hdr_data;
  logic [31:0] target;
  logic        hash_start;
  logic        hash_done;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        busy;
  logic        result_valid;
  logic        found;
  logic [7:0]  best_nonce;
  logic [31:0] best_hash;

  always #5 clk = ~clk;

  hash_job_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_data(hdr_data), .target(target),
    .hash_start(hash_start), .hash_done(hash_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .busy(busy), .result_valid(result_valid), .found(found),
    .best_nonce(best_nonce), .best_hash(best_hash)
  );

  // field order: target, base, inc, dip_a, dip_b, dip_val, toggle, stale, done_at, exp_found, exp_nonce, exp_hash
  typedef struct {
    logic [31:0] target;
    logic [31:0] base;
    logic [31:0] inc;
    int          dip_a;
    int          dip_b;
    logic [31:0] dip_val;
    bit          toggle;
    bit          stale;
    int          done_at;
    bit          exp_found;
    logic [7:0]  exp_nonce;
    logic [31:0] exp_hash;
  } vec_t;

  typedef struct {
    bit          f;
    logic [7:0]  n;
    logic [31:0] h;
  } exp_t;

  vec_t        vecs [0:5];
  exp_t        sb [$];
  int          total = 0;
  int          bad = 0;
  int          starts = 0;
  logic [31:0] hdr_mem [0:31];
  logic [31:0] res_mem [0:15];
  logic [31:0] p1, p2;

  // Memory model: writes land in hdr_mem, reads return res_mem after two cycles.
  always @(posedge clk) begin
    if (mem_we && mem_addr < 16'd32) hdr_mem[mem_addr[4:0]] <= mem_write_data;
    p1 <= (mem_addr >= 16'h40 && mem_addr < 16'h50) ? res_mem[mem_addr[3:0]] : 32'hDEAD_BEEF;
    p2 <= p1;
  end
  assign mem_read_data = p2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (hash_start) starts++;
    if (result_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_found", {31'd0, found}, {31'd0, e.f});
        chk("sb_best_nonce", {24'd0, best_nonce}, {24'd0, e.n});
        chk("sb_best_hash", best_hash, e.h);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int vi, input int abort_at);
    vec_t v;
    exp_t e;
    int   k, cyc, s0, exp_rv;
    bit   seen, vld;
    v = vecs[vi];
    for (int i = 0; i < NN; i++)
      res_mem[i] = (i == v.dip_a || i == v.dip_b) ? v.dip_val : v.base + v.inc * 32'(i);
    if (abort_at < 0) begin
      e.f = v.exp_found; e.n = v.exp_nonce; e.h = v.exp_hash;
      sb.push_back(e);
    end
    s0 = starts; k = 0; cyc = 0;
    while (k < HWORDS && cyc < 100) begin
      vld       = !v.toggle || (cyc % 2 == 0);
      hdr_valid = vld;
      hdr_data  = 32'h1000 + 32'(k) + (32'(vi) << 12);
      target    = (k == 0) ? v.target : ~v.target;
      @(negedge clk);
      chk("load_ready", {31'd0, hdr_ready}, 32'd1);
      chk("load_we", {31'd0, mem_we}, {31'd0, vld});
      if (vld) begin
        chk("load_addr", {16'd0, mem_addr}, 32'(k));
        chk("load_wdata", mem_write_data, hdr_data);
      end
      next_cycle();
      if (vld) k++;
      cyc++;
    end
    if (k < HWORDS) chk("load_timeout", 32'd0, 32'd1);
    exp_rv = v.done_at + NN + 3;
    seen = 1'b0;
    for (int c = 0; c <= exp_rv + 5 && !seen; c++) begin
      hash_done = (v.stale && c <= 2) || (c >= v.done_at);
      hdr_valid = (c < v.done_at);
      @(negedge clk);
      chk("start_pulse", {31'd0, hash_start}, {31'd0, (c == 0)});
      chk("job_busy", {31'd0, busy}, 32'd1);
      chk("job_ready_low", {31'd0, hdr_ready}, 32'd0);
      chk("job_we_low", {31'd0, mem_we}, 32'd0);
      if (c == v.done_at + 1) chk("read_first_addr", {16'd0, mem_addr}, 32'h40);
      if (c == v.done_at + NN) chk("read_last_addr", {16'd0, mem_addr}, 32'h4F);
      if (result_valid) begin
        seen = 1'b1;
        chk("rv_cycle", 32'(c), 32'(exp_rv));
      end
      if (c == abort_at) begin
        next_cycle();
        reset_n = 1'b0;
        hdr_valid = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, hdr_ready}, 32'd1);
        chk("abort_rv", {31'd0, result_valid}, 32'd0);
        for (int j = 0; j < 25; j++) begin
          next_cycle();
          @(negedge clk);
          chk("abort_no_rv", {31'd0, result_valid}, 32'd0);
        end
        next_cycle();
        return;
      end
      if (!seen) next_cycle();
    end
    if (!seen) chk("rv_timeout", 32'd0, 32'd1);
    chk("start_count", 32'(starts - s0), 32'd1);
    for (int i = 0; i < HWORDS; i++)
      chk("hdr_mem", hdr_mem[i], 32'h1000 + 32'(i) + (32'(vi) << 12));
    next_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h9000_0000, 32'h9000_0000, 32'hFFFF_FFFF, -1, -1, 32'h0, 1'b0, 1'b0, 3, 1'b1, 8'd15, 32'h8FFF_FFF1};
    vecs[1] = '{32'd5, 32'd5, 32'd0, -1, -1, 32'h0, 1'b1, 1'b1, 10, 1'b0, 8'd0, 32'd5};
    vecs[2] = '{32'd0, 32'h100, 32'd1, -1, -1, 32'h0, 1'b0, 1'b0, 5, 1'b0, 8'd0, 32'h100};
    vecs[3] = '{32'd4, 32'd1000, 32'd1, 7, 12, 32'd3, 1'b1, 1'b1, 12, 1'b1, 8'd7, 32'd3};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, -1, -1, 32'h0, 1'b0, 1'b0, 3, 1'b0, 8'd0, 32'hFFFF_FFFF};
    vecs[5] = '{32'd1, 32'd0, 32'd0, -1, -1, 32'h0, 1'b0, 1'b1, 4, 1'b1, 8'd0, 32'd0};

    reset_n = 1'b0; hdr_valid = 1'b0; hdr_data = 32'h0; target = 32'h0; hash_done = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_hash_start", {31'd0, hash_start}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_found", {31'd0, found}, 32'd0);
    chk("rst_best_nonce", {24'd0, best_nonce}, 32'd0);
    chk("rst_best_hash", best_hash, 32'hFFFF_FFFF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, hdr_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    next_cycle();

    for (int vi = 0; vi < 6; vi++) run_job(vi, -1);
    run_job(2, vecs[2].done_at + 8);
    run_job(0, -1);

    for (int j = 0; j < 3; j++) next_cycle();
    @(negedge clk);
    chk("hold_found", {31'd0, found}, 32'd1);
    chk("hold_best_nonce", {24'd0, best_nonce}, 32'd15);
    chk("hold_best_hash", best_hash, 32'h8FFF_FFF1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hash_job_ctrl.md
HASH_JOB_CTRL -- requirements
Module: hash_job_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_NONCES, 16, number of result words read back.
- MSG_BASE, 16'h0000, memory word address of header word 0.
- OUT_BASE, 16'h0040, memory word address of result for nonce 0.
- HDR_WORDS, 19, header words loaded per job.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- reset_n, in, 1, synchronous active-low reset.
- hdr_valid, in, 1, header word offered.
- hdr_ready, out, 1, header word accepted when valid&ready.
- hdr_data, in, 32, header word.
- target, in, 32, unsigned threshold; sampled on the first header handshake of a job.
- hash_start, out, 1, one-cycle start pulse to hasher.
- hash_done, in, 1, hasher completion level.
- mem_we, out, 1, memory write enable.
- mem_addr, out, 16, memory word address.
- mem_write_data, out, 32, memory write data.
- mem_read_data, in, 32, memory read data; valid 2 cycles after mem_addr is presented.
- busy, out, 1, high in every state except IDLE.
- result_valid, out, 1, one-cycle result pulse.
- found, out, 1, at least one result word < target.
- best_nonce, out, 8, lowest nonce index holding the minimum result word.
- best_hash, out, 32, minimum result word.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, START, WAIT, READ, REPORT.
REQ-004 IDLE: hdr_ready=1; on the first handshake, write word 0 at MSG_BASE in the same cycle (mem_we=1), latch target, go to LOAD.
REQ-005 LOAD: hdr_ready=1; each handshake writes hdr_data to MSG_BASE+k, k=1..HDR_WORDS-1, same cycle. Cycles without valid write nothing (mem_we=0). After word HDR_WORDS-1, go to START.
REQ-006 START: hdr_ready=0; assert hash_start for exactly one cycle, mem_we=0; go to WAIT.
REQ-007 WAIT: ignore hash_done for the first 2 cycles after the hash_start cycle (stale done from the previous job). Afterwards, the first sample of hash_done=1 moves to READ. There is no timeout.
REQ-008 READ: mem_we=0. Present addresses OUT_BASE+0 .. OUT_BASE+NUM_NONCES-1 on consecutive cycles. Capture the word for nonce i two cycles after its address. READ lasts NUM_NONCES+2 cycles.
REQ-009 Compare each captured word as unsigned 32-bit:
- The running minimum updates only on strictly-less, so ties keep the lowest nonce.
- found is set if any word < target (strict).
- target=0 never sets found.
REQ-010 REPORT: drive result_valid=1 for one cycle, with found/best_nonce/best_hash valid. These three outputs hold until the next REPORT. Go to IDLE.
REQ-011 hdr_ready SHALL be 0 in START, WAIT, READ, REPORT. hdr_valid in those states is ignored and not consumed.
REQ-012 mem_addr and mem_write_data are don't-care when mem_we=0 outside READ. mem_we SHALL be 0 outside IDLE/LOAD handshake cycles.
REQ-013 best_nonce is zero-extended to 8 bits. The counter is wide enough for NUM_NONCES+2 without wrap.
REQ-014 Back-to-back jobs: a handshake in the IDLE cycle immediately after REPORT starts a new job and clears the running minimum to 32'hFFFFFFFF and found to 0.

Reset
REQ-015 reset_n=0 at a rising edge SHALL force:
- state IDLE;
- hash_start=0, mem_we=0, result_valid=0, found=0;
- best_nonce=0, best_hash=32'hFFFFFFFF, busy=0;
- mem_addr=0, mem_write_data=0.
hdr_ready is 1 on the first cycle after reset release.
REQ-016 Reset asserted mid-job (any state) SHALL abort the job. The partial header is not resumed, and no result_valid is produced for it.

Verification
REQ-017 Load 19 words 32'h1000+k, valid every cycle, target=32'h8000_0000:
- memory MSG_BASE..+18 holds 32'h1000..32'h1012;
- hash_start pulses exactly once, on the cycle after the 19th handshake.
REQ-018 Memory model returns result words 32'h9000_0000-i (i=0..15), target=32'h9000_0000:
- found=1, best_nonce=15, best_hash=32'h8FFF_FFF1;
- result_valid appears NUM_NONCES+3 cycles after the hash_done sample.
REQ-019 All result words 32'h0000_0005, target=5 -> found=0, best_nonce=0, best_hash=5.
REQ-020 hash_done held high from the previous job during START and WAIT, new done raised 10 cycles later -> READ entered only after the new done; no early read.
REQ-021 hdr_valid toggling 1,0,1,0 during LOAD -> only the valid cycles write; addresses stay contiguous.
REQ-022 reset_n=0 for one cycle while in READ -> busy=0 and hdr_ready=1 next cycle, no result_valid; the following full job reports correctly.
